// File: rtl/rv32i_mem_stage_hs.sv
// rtl/rv32i_mem_stage_hs.sv - RV32I memory stage with req/ack bus, load alignment, fault and timeout handling
module rv32i_mem_stage_hs #(
  parameter int ADDR_W     = 32,
  parameter int IO_SEL_BIT = 31,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       iw_in,
  input  logic [ADDR_W-1:0] alu_in,
  input  logic [31:0]       rs2_data_in,
  input  logic              wb_en_in,
  input  logic [4:0]        wb_reg_in,
  output logic              stall_out,
  output logic [ADDR_W-3:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  output logic              bus_we,
  output logic              mem_req,
  output logic              io_req,
  input  logic              mem_ack,
  input  logic              io_ack,
  input  logic [31:0]       mem_rdata,
  input  logic [31:0]       io_rdata,
  output logic              out_valid,
  output logic [31:0]       pc_out,
  output logic [31:0]       iw_out,
  output logic [31:0]       wb_data_out,
  output logic              wb_en_out,
  output logic [4:0]        wb_reg_out,
  output logic              fault_out,
  output logic [1:0]        fault_code,
  output logic              df_mem_enable,
  output logic [4:0]        df_mem_reg,
  output logic [31:0]       df_mem_data
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state;
  logic [7:0]        cnt;
  logic [ADDR_W-1:0] h_alu;
  logic [2:0]        h_f3;
  logic              h_io, h_load, h_wb_en;
  logic [31:0]       h_pc, h_iw;
  logic [4:0]        h_wb_reg;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [1:0]  size, lane;
  logic        is_load, is_store, is_access, illegal, misaligned, fault;
  logic [1:0]  code;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack_sel;
  logic [31:0] rdata_sel;

  always_comb begin
    opcode     = iw_in[6:0];
    f3         = iw_in[14:12];
    size       = f3[1:0];
    lane       = alu_in[1:0];
    is_load    = (opcode == 7'b0000011);
    is_store   = (opcode == 7'b0100011);
    is_access  = is_load | is_store;
    illegal    = (size == 2'b11);
    misaligned = ((size == 2'b01) && lane[0]) || ((size == 2'b10) && (lane != 2'b00));
    fault      = is_access && (illegal || misaligned);
    code       = illegal ? 2'b11 : 2'b01;
    case (size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      default: be = 4'b1111;
    endcase
    wdata     = rs2_data_in << {lane, 3'b000};
    ack_sel   = h_io ? io_ack : mem_ack;
    rdata_sel = h_io ? io_rdata : mem_rdata;
  end

  function automatic logic [31:0] load_ext(input logic [31:0] rd, input logic [1:0] ln,
                                           input logic [2:0] fn);
    logic [31:0] s;
    s = rd >> {ln, 3'b000};
    case (fn)
      3'b000:  load_ext = {{24{s[7]}}, s[7:0]};
      3'b100:  load_ext = {24'b0, s[7:0]};
      3'b001:  load_ext = {{16{s[15]}}, s[15:0]};
      3'b101:  load_ext = {16'b0, s[15:0]};
      default: load_ext = s;
    endcase
  endfunction

  assign stall_out     = (state == S_WAIT);
  assign df_mem_enable = out_valid & wb_en_out;
  assign df_mem_reg    = wb_reg_out;
  assign df_mem_data   = wb_data_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
      bus_we      <= 1'b0;
      mem_req     <= 1'b0;
      io_req      <= 1'b0;
      h_alu       <= '0;
      h_f3        <= '0;
      h_io        <= 1'b0;
      h_load      <= 1'b0;
      h_wb_en     <= 1'b0;
      h_pc        <= '0;
      h_iw        <= '0;
      h_wb_reg    <= '0;
      out_valid   <= 1'b0;
      pc_out      <= '0;
      iw_out      <= '0;
      wb_data_out <= '0;
      wb_en_out   <= 1'b0;
      wb_reg_out  <= '0;
      fault_out   <= 1'b0;
      fault_code  <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && is_access && !fault) begin
            bus_addr  <= alu_in[ADDR_W-1:2];
            bus_be    <= be;
            bus_wdata <= wdata;
            bus_we    <= is_store;
            mem_req   <= !alu_in[IO_SEL_BIT];
            io_req    <= alu_in[IO_SEL_BIT];
            h_alu     <= alu_in;
            h_f3      <= f3;
            h_io      <= alu_in[IO_SEL_BIT];
            h_load    <= is_load;
            h_wb_en   <= wb_en_in;
            h_pc      <= pc_in;
            h_iw      <= iw_in;
            h_wb_reg  <= wb_reg_in;
            cnt       <= '0;
            state     <= S_WAIT;
          end else if (in_valid) begin
            out_valid   <= 1'b1;
            pc_out      <= pc_in;
            iw_out      <= iw_in;
            wb_data_out <= 32'(alu_in);
            wb_en_out   <= wb_en_in & !fault;
            wb_reg_out  <= wb_reg_in;
            fault_out   <= fault;
            fault_code  <= fault ? code : 2'b00;
          end
        end
        S_WAIT: begin
          // ack is checked first so that an ack on the last allowed cycle still completes cleanly
          if (ack_sel || (cnt == 8'(TIMEOUT - 1))) begin
            mem_req     <= 1'b0;
            io_req      <= 1'b0;
            bus_we      <= 1'b0;
            state       <= S_IDLE;
            out_valid   <= 1'b1;
            pc_out      <= h_pc;
            iw_out      <= h_iw;
            wb_reg_out  <= h_wb_reg;
            wb_data_out <= (ack_sel && h_load) ? load_ext(rdata_sel, h_alu[1:0], h_f3) : 32'(h_alu);
            wb_en_out   <= ack_sel & h_load & h_wb_en;
            fault_out   <= !ack_sel;
            fault_code  <= ack_sel ? 2'b00 : 2'b10;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mem_stage_hs.sv
// tb/tb_rv32i_mem_stage_hs.sv - scoreboard bench for the handshaked RV32I memory stage
module tb_rv32i_mem_stage_hs;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] pc_in = '0, iw_in = '0, alu_in = '0, rs2_data_in = '0;
  logic        wb_en_in = 1'b0;
  logic [4:0]  wb_reg_in = '0;
  logic        stall_out;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_we, mem_req, io_req;
  logic        mem_ack = 1'b0, io_ack = 1'b0;
  logic [31:0] mem_rdata = '0, io_rdata = '0;
  logic        out_valid;
  logic [31:0] pc_out, iw_out, wb_data_out;
  logic        wb_en_out;
  logic [4:0]  wb_reg_out;
  logic        fault_out;
  logic [1:0]  fault_code;
  logic        df_mem_enable;
  logic [4:0]  df_mem_reg;
  logic [31:0] df_mem_data;

  rv32i_mem_stage_hs #(.ADDR_W(32), .IO_SEL_BIT(31), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .pc_in(pc_in), .iw_in(iw_in),
    .alu_in(alu_in), .rs2_data_in(rs2_data_in), .wb_en_in(wb_en_in), .wb_reg_in(wb_reg_in),
    .stall_out(stall_out), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .mem_req(mem_req), .io_req(io_req), .mem_ack(mem_ack), .io_ack(io_ack),
    .mem_rdata(mem_rdata), .io_rdata(io_rdata), .out_valid(out_valid), .pc_out(pc_out),
    .iw_out(iw_out), .wb_data_out(wb_data_out), .wb_en_out(wb_en_out), .wb_reg_out(wb_reg_out),
    .fault_out(fault_out), .fault_code(fault_code), .df_mem_enable(df_mem_enable),
    .df_mem_reg(df_mem_reg), .df_mem_data(df_mem_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        chk_data;
    logic        wb_en;
    logic [4:0]  wreg;
    logic        fault;
    logic [1:0]  code;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_iw(input logic [2:0] f3, input logic [6:0] op);
    mk_iw = {17'h0, f3, 5'd1, op};
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] pc, input logic [31:0] data, input logic cd,
                                  input logic en, input logic [4:0] r, input logic f,
                                  input logic [1:0] c);
    mk_exp.pc = pc; mk_exp.data = data; mk_exp.chk_data = cd; mk_exp.wb_en = en;
    mk_exp.wreg = r; mk_exp.fault = f; mk_exp.code = c;
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pc_out", pc_out, e.pc);
        if (e.chk_data) check("wb_data_out", wb_data_out, e.data);
        check("wb_en_out", {31'b0, wb_en_out}, {31'b0, e.wb_en});
        check("wb_reg_out", {27'b0, wb_reg_out}, {27'b0, e.wreg});
        check("fault_out", {31'b0, fault_out}, {31'b0, e.fault});
        check("fault_code", {30'b0, fault_code}, {30'b0, e.code});
        check("df_mem_enable", {31'b0, df_mem_enable}, {31'b0, e.wb_en});
      end
    end
  end

  task automatic issue(input logic [31:0] pc, input logic [31:0] iw, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic en, input logic [4:0] r);
    pc_in = pc; iw_in = iw; alu_in = alu; rs2_data_in = rs2; wb_en_in = en; wb_reg_in = r;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // k cycles of WAIT, ack on the k-th; optional stray ack on the other channel in cycle 1
  task automatic respond(input logic io, input int k, input logic [31:0] rdata,
                         input logic [3:0] be, input logic [31:0] wd, input logic we,
                         input logic stray);
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      check("stall_wait", {31'b0, stall_out}, 32'd1);
      check("mem_req", {31'b0, mem_req}, {31'b0, !io});
      check("io_req", {31'b0, io_req}, {31'b0, io});
      check("bus_be", {28'b0, bus_be}, {28'b0, be});
      check("bus_wdata", bus_wdata, wd);
      check("bus_we", {31'b0, bus_we}, {31'b0, we});
      check("out_valid_wait", {31'b0, out_valid}, 32'd0);
      if (i == k) begin
        if (io) begin io_ack = 1'b1; io_rdata = rdata; end
        else begin mem_ack = 1'b1; mem_rdata = rdata; end
      end else if (stray && i == 1) begin
        if (io) mem_ack = 1'b1; else io_ack = 1'b1;
      end
      @(posedge clk);
      #1 mem_ack = 1'b0; io_ack = 1'b0;
    end
    @(negedge clk);
    check("stall_after_ack", {31'b0, stall_out}, 32'd0);
    check("req_after_ack", {30'b0, mem_req, io_req}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_stall", {31'b0, stall_out}, 32'd0);
    check("rst_req", {29'b0, mem_req, io_req, bus_we}, 32'd0);
    check("rst_fault", {29'b0, fault_out, fault_code}, 32'd0);
    check("rst_data", wb_data_out, 32'd0);
    check("rst_pc", pc_out, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // reset while a load is pending discards it
    issue(32'h0000_1000, mk_iw(3'b010, 7'b0000011), 32'h0000_0100, 32'h0, 1'b1, 5'd3);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rstw_mem_req", {31'b0, mem_req}, 32'd0);
    check("rstw_stall", {31'b0, stall_out}, 32'd0);
    check("rstw_out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // ADD: single-cycle result with forwarding
    sb.push_back(mk_exp(32'h0000_1004, 32'h0000_0010, 1'b1, 1'b1, 5'd5, 1'b0, 2'b00));
    issue(32'h0000_1004, 32'h0000_0033, 32'h0000_0010, 32'h0, 1'b1, 5'd5);
    @(negedge clk);
    check("add_stall", {31'b0, stall_out}, 32'd0);
    check("add_valid", {31'b0, out_valid}, 32'd1);
    check("add_df_reg", {27'b0, df_mem_reg}, 32'd5);
    check("add_df_data", df_mem_data, 32'h10);
    @(negedge clk);
    check("idle_no_valid", {31'b0, out_valid}, 32'd0);

    // LB / LBU at lane 3, ack after 3 cycles
    sb.push_back(mk_exp(32'h0000_1008, 32'hFFFF_FF80, 1'b1, 1'b1, 5'd7, 1'b0, 2'b00));
    issue(32'h0000_1008, mk_iw(3'b000, 7'b0000011), 32'h0000_0103, 32'h0, 1'b1, 5'd7);
    @(negedge clk);
    check("lb_bus_addr", {2'b0, bus_addr}, 32'h0000_0040);
    respond(1'b0, 3, 32'h80FF_1234, 4'b1000, 32'h0, 1'b0, 1'b0);
    sb.push_back(mk_exp(32'h0000_100C, 32'h0000_0080, 1'b1, 1'b1, 5'd8, 1'b0, 2'b00));
    issue(32'h0000_100C, mk_iw(3'b100, 7'b0000011), 32'h0000_0103, 32'h0, 1'b1, 5'd8);
    respond(1'b0, 2, 32'h80FF_1234, 4'b1000, 32'h0, 1'b0, 1'b0);

    // LHU lane 2 on IO with a stray memory ack that must be ignored
    sb.push_back(mk_exp(32'h0000_1010, 32'h0000_BEEF, 1'b1, 1'b1, 5'd9, 1'b0, 2'b00));
    issue(32'h0000_1010, mk_iw(3'b101, 7'b0000011), 32'h8000_0012, 32'h0, 1'b1, 5'd9);
    respond(1'b1, 3, 32'hBEEF_1111, 4'b1100, 32'h0, 1'b0, 1'b1);

    // SH to IO
    sb.push_back(mk_exp(32'h0000_1014, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00));
    issue(32'h0000_1014, mk_iw(3'b001, 7'b0100011), 32'h8000_0002, 32'h0000_ABCD, 1'b0, 5'd0);
    respond(1'b1, 1, 32'h0, 4'b1100, 32'hABCD_0000, 1'b1, 1'b0);

    // misaligned LW and illegal width: no request, faulted result
    sb.push_back(mk_exp(32'h0000_1018, 32'h0, 1'b0, 1'b0, 5'd4, 1'b1, 2'b01));
    issue(32'h0000_1018, mk_iw(3'b010, 7'b0000011), 32'h0000_0006, 32'h0, 1'b1, 5'd4);
    @(negedge clk);
    check("mis_no_req", {30'b0, mem_req, io_req}, 32'd0);
    check("mis_stall", {31'b0, stall_out}, 32'd0);
    sb.push_back(mk_exp(32'h0000_101C, 32'h0, 1'b0, 1'b0, 5'd4, 1'b1, 2'b11));
    issue(32'h0000_101C, mk_iw(3'b011, 7'b0000011), 32'h0000_0000, 32'h0, 1'b1, 5'd4);
    @(negedge clk);
    check("ill_no_req", {30'b0, mem_req, io_req}, 32'd0);

    // timeout: 16 WAIT cycles, then abort
    sb.push_back(mk_exp(32'h0000_1020, 32'h0, 1'b0, 1'b0, 5'd6, 1'b1, 2'b10));
    issue(32'h0000_1020, mk_iw(3'b010, 7'b0000011), 32'h0000_0200, 32'h0, 1'b1, 5'd6);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check("to_req_held", {31'b0, mem_req}, 32'd1);
    end
    @(negedge clk);
    check("to_req_dropped", {31'b0, mem_req}, 32'd0);
    check("to_stall", {31'b0, stall_out}, 32'd0);

    // ack on the 16th WAIT cycle wins over the timeout
    sb.push_back(mk_exp(32'h0000_1024, 32'h1234_5678, 1'b1, 1'b1, 5'd6, 1'b0, 2'b00));
    issue(32'h0000_1024, mk_iw(3'b010, 7'b0000011), 32'h0000_0200, 32'h0, 1'b1, 5'd6);
    respond(1'b0, 16, 32'h1234_5678, 4'b1111, 32'h0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/rv32i_mem_stage_hs.md
# rv32i_mem_stage_hs

Parametrised, handshaked successor of the RV32I memory pipeline stage. It sits between the execute stage and the writeback stage. It issues load and store accesses over a req/ack bus to either the memory or the IO channel, and stalls the upstream pipeline while an access is outstanding. It also aligns and extends load data inside the stage, detects misaligned or illegal accesses, and aborts accesses that exceed a timeout.

## Interface
Parameters:
- ADDR_W, 32: byte-address width; bus word address is ADDR_W-1:2.
- IO_SEL_BIT, 31: alu_in bit that selects the IO channel (1 = IO, 0 = memory).
- TIMEOUT, 16: maximum WAIT cycles without ack before abort; legal range 2..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  execute-stage instruction valid
- pc_in, iw_in  in  32  PC and instruction word
- alu_in  in  ADDR_W  effective address or ALU result
- rs2_data_in  in  32  store data
- wb_en_in  in  1  register write enable
- wb_reg_in  in  5  destination register
- stall_out  out  1  upstream must hold its inputs
- bus_addr  out  ADDR_W-2  word address
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-shifted store data
- bus_we  out  1  write strobe qualifier
- mem_req, io_req  out  1  per-channel request
- mem_ack, io_ack  in  1  per-channel completion
- mem_rdata, io_rdata  in  32  read data, valid with ack
- out_valid  out  1  result valid to writeback
- pc_out, iw_out  out  32  passed through
- wb_data_out  out  32  aligned load data or ALU result
- wb_en_out  out  1  register write enable to writeback
- wb_reg_out  out  5  destination register to writeback
- fault_out  out  1  access fault
- fault_code  out  2  01 misaligned, 10 timeout, 11 illegal width
- df_mem_enable, df_mem_reg, df_mem_data  out  1/5/32  forwarding to decode and execute

## Operation
- Decode: opcode = iw_in[6:0]. Load = 0000011; store = 0100011. f3 = iw_in[14:12]; size = f3[1:0] (00 byte, 01 half, 10 word, 11 illegal); lane = alu_in[1:0].
- Faults:
  - size 11 gives code 11.
  - Half with lane[0]=1 gives code 01.
  - Word with lane!=0 gives code 01.
  - A faulted access issues no request. Its result is out_valid=1, fault_out=1, wb_en_out=0.
- Byte enables: byte 0001<<lane; half 0011<<lane; word 1111. bus_wdata = rs2_data_in << (8*lane).
- Load extension: f3 000 sign-extends byte, 100 zero-extends byte, 001 sign-extends half, 101 zero-extends half, 010 word. Data is taken from the lane selected in mem_rdata or io_rdata.
- FSM states IDLE and WAIT:
  - IDLE with in_valid and a legal access: latch the transaction (address, be, wdata, we, channel, f3, pc, iw, wb fields) into holding registers and go to WAIT. Clear the timeout counter.
  - IDLE with in_valid and a non-access or faulted instruction: register the result; stay in IDLE.
  - WAIT: exactly one of mem_req/io_req is high, driven from the holding registers. The bus signals stay stable until ack.
  - WAIT with the selected channel's ack: register the result and go to IDLE.
  - WAIT without ack: increment the counter. When the counter reaches TIMEOUT-1 without ack, drop req, go to IDLE, and emit a result with code 10 and wb_en_out=0.
  - The non-selected channel's ack is ignored.
- Results by type: non-access results carry wb_data_out = alu_in. Store results carry wb_en_out=0.
- Forwarding:
  - df_mem_enable = out_valid & wb_en_out.
  - df_mem_reg = wb_reg_out.
  - df_mem_data = wb_data_out.

## Timing
- Reset: every registered output is 0, including out_valid, fault_out, fault_code, all data and pc/iw outputs. The state is IDLE, the counter is 0, and mem_req, io_req, bus_we and stall_out are 0. Reset during WAIT drops req at that edge and discards the transaction with no result.
- stall_out = (state == WAIT), combinational. It stays high through the ack cycle inclusive. The next instruction is accepted on the first IDLE cycle.
- Non-access or faulted instruction: result at the edge after acceptance (1-cycle latency), no stall.
- Access accepted at cycle T: req is high from T+1. If ack arrives in cycle T+k (k≥1), the result is registered at the end of T+k with out_valid=1 in T+k+1. Minimum occupancy is 2 cycles.
- out_valid is a single-cycle pulse per result. It is 0 in cycles with no new result, including all WAIT cycles.
- Ack and timeout in the same cycle: ack wins and the result carries no fault.
- in_valid=0 in IDLE produces out_valid=0 in the next cycle.

## Test plan
- Reset mid-WAIT (LW pending, reset at cycle 3) -> next cycle mem_req=0, stall_out=0, out_valid=0; the following ADD completes normally.
- ADD with alu_in=0x0000_0010, wb_reg_in=5 -> one cycle later: out_valid=1, wb_data_out=0x10, df_mem_reg=5, stall_out never high.
- LB at 0x0000_0103, ack after 3 cycles with mem_rdata=0x80FF_1234 -> bus_be=1000; stall_out high for 3 cycles; wb_data_out=0xFFFF_FF80. LBU on the same data -> 0x0000_0080.
- SH at 0x8000_0002 with rs2=0x0000_ABCD -> io_req=1, mem_req=0, bus_be=1100, bus_wdata=0xABCD_0000, bus_we=1, wb_en_out=0.
- LW at 0x0000_0006 -> no req; result with fault_code=01, wb_en_out=0. f3=011 -> fault_code=11.
- LW with ack never asserted, TIMEOUT=16 -> req drops after 16 WAIT cycles, fault_code=10. Repeat with ack in the 16th cycle -> no fault and data delivered.
